ov7670_sccb_config: RTL and testbench

Register-configuration sequencer for the OV7670 camera, sitting beside the pixel-capture path on the camera side of the design. On `start` it walks an external register table, issues one SCCB 3-phase write (device ID, sub-address, data) per entry on the camera's SIOC/SIOD pins, honours in-table delay markers, and raises `done` when the table ends. The capture path's output is only meaningful after `done`.

---
 rtl/ov7670_sccb_config.sv | 163 ++++++++++++++++
 tb/tb_ov7670_sccb_config.sv | 280 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ov7670_sccb_config.sv
// OV7670 register-table sequencer: walks an external ROM and issues one SCCB
// 3-phase write (ID, sub-address, data) per entry on SIOC/SIOD.
module ov7670_sccb_config #(
  parameter int unsigned QTR_CYCLES   = 63,
  parameter int unsigned DELAY_CYCLES = 250000,
  parameter logic [7:0]  DEV_ADDR     = 8'h42
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  rom_addr,
  input  logic [15:0] rom_data,
  output logic        sioc,
  output logic        siod_out,
  output logic        siod_oe,
  input  logic        siod_in,
  output logic        busy,
  output logic        done,
  output logic        ack_err
);

  localparam int unsigned QW = (QTR_CYCLES > 1) ? $clog2(QTR_CYCLES) : 1;
  localparam int unsigned DW = (DELAY_CYCLES > 1) ? $clog2(DELAY_CYCLES) : 1;
  localparam logic [QW-1:0] QMAX = QW'(QTR_CYCLES - 1);
  localparam logic [DW-1:0] DMAX = DW'(DELAY_CYCLES - 1);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_START, S_BITS, S_STOP, S_GAP, S_DELAY, S_FINISH
  } state_t;

  state_t      state, state_n;
  logic [QW-1:0] qcnt, qcnt_n;
  logic [1:0]  qtr, qtr_n;
  logic [4:0]  slot, slot_n;
  logic [DW-1:0] dcnt, dcnt_n;
  logic [26:0] frame, frame_n;
  logic [7:0]  rom_addr_n;
  logic        busy_n, done_n, ack_err_n;
  logic        sioc_n, siod_out_n, siod_oe_n;
  logic        tick, qtr_last, ack_slot, bit_val;

  assign tick     = (qcnt == QMAX);
  assign qtr_last = tick && (qtr == 2'd3);
  assign ack_slot = (slot == 5'd8) || (slot == 5'd17) || (slot == 5'd26);
  assign bit_val  = frame[5'd26 - slot];

  // Line values are decoded from the current state and registered, so the
  // pins trail the state register by one cycle; relative timing is unchanged.
  always_comb begin
    state_n    = state;
    qcnt_n     = tick ? '0 : qcnt + QW'(1);
    qtr_n      = tick ? qtr + 2'd1 : qtr;
    slot_n     = slot;
    dcnt_n     = dcnt;
    frame_n    = frame;
    rom_addr_n = rom_addr;
    busy_n     = busy;
    done_n     = done;
    ack_err_n  = ack_err;
    sioc_n     = 1'b1;
    siod_out_n = 1'b1;
    siod_oe_n  = 1'b0;
    case (state)
      S_IDLE: begin
        if (start) begin
          rom_addr_n = '0;
          busy_n     = 1'b1;
          done_n     = 1'b0;
          ack_err_n  = 1'b0;
          state_n    = S_FETCH;
        end
      end
      S_FETCH: state_n = S_DECODE;
      S_DECODE: begin
        qcnt_n = '0;
        qtr_n  = '0;
        slot_n = '0;
        dcnt_n = '0;
        if (rom_data == 16'hFFFF) begin
          state_n = S_FINISH;
        end else if (rom_data == 16'hFFF0) begin
          state_n = S_DELAY;
        end else begin
          // Ack positions hold 1 so the frame can be indexed uniformly.
          frame_n = {DEV_ADDR, 1'b1, rom_data[15:8], 1'b1, rom_data[7:0], 1'b1};
          state_n = S_START;
        end
      end
      S_START: begin
        siod_oe_n  = 1'b1;
        sioc_n     = (qtr != 2'd3);
        siod_out_n = (qtr == 2'd0);
        if (qtr_last) state_n = S_BITS;
      end
      S_BITS: begin
        sioc_n     = (qtr == 2'd1) || (qtr == 2'd2);
        siod_oe_n  = !ack_slot;
        siod_out_n = bit_val;
        if (ack_slot && (qtr == 2'd2) && tick && siod_in) ack_err_n = 1'b1;
        if (qtr_last) begin
          if (slot == 5'd26) state_n = S_STOP;
          else               slot_n  = slot + 5'd1;
        end
      end
      S_STOP: begin
        siod_oe_n  = 1'b1;
        sioc_n     = (qtr != 2'd0);
        siod_out_n = qtr[1];
        if (qtr_last) state_n = S_GAP;
      end
      S_GAP, S_DELAY: begin
        if (state == S_DELAY) dcnt_n = dcnt + DW'(1);
        if ((state == S_GAP) ? qtr_last : (dcnt == DMAX)) begin
          if (rom_addr == 8'hFF) begin
            state_n = S_FINISH;
          end else begin
            rom_addr_n = rom_addr + 8'd1;
            state_n    = S_FETCH;
          end
        end
      end
      S_FINISH: begin
        busy_n  = 1'b0;
        done_n  = 1'b1;
        state_n = S_IDLE;
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= S_IDLE;
      qcnt     <= '0;
      qtr      <= '0;
      slot     <= '0;
      dcnt     <= '0;
      frame    <= '0;
      rom_addr <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      ack_err  <= 1'b0;
      sioc     <= 1'b1;
      siod_out <= 1'b1;
      siod_oe  <= 1'b0;
    end else begin
      state    <= state_n;
      qcnt     <= qcnt_n;
      qtr      <= qtr_n;
      slot     <= slot_n;
      dcnt     <= dcnt_n;
      frame    <= frame_n;
      rom_addr <= rom_addr_n;
      busy     <= busy_n;
      done     <= done_n;
      ack_err  <= ack_err_n;
      sioc     <= sioc_n;
      siod_out <= siod_out_n;
      siod_oe  <= siod_oe_n;
    end
  end

endmodule

// File: tb/tb_ov7670_sccb_config.sv
// Bench for ov7670_sccb_config: per-cycle comparison against a transaction-level
// waveform model, plus an SCCB byte decoder and literal latency expectations.
module tb_ov7670_sccb_config;

  localparam int QTR = 2;
  localparam int DLY = 10;

  logic        clk, rst, start, siod_in;
  logic [7:0]  rom_addr;
  logic [15:0] rom_data;
  logic        sioc, siod_out, siod_oe, busy, done, ack_err;

  ov7670_sccb_config #(
    .QTR_CYCLES  (QTR),
    .DELAY_CYCLES(DLY),
    .DEV_ADDR    (8'h42)
  ) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .rom_addr(rom_addr),
    .rom_data(rom_data),
    .sioc    (sioc),
    .siod_out(siod_out),
    .siod_oe (siod_oe),
    .siod_in (siod_in),
    .busy    (busy),
    .done    (done),
    .ack_err (ack_err)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  logic [15:0] rom [256];
  always @(posedge clk) rom_data <= rom[rom_addr];

  typedef struct packed { logic busy, done, aerr, din; logic [7:0] addr; } st_t;
  typedef struct packed { logic sioc, oe, out; } ln_t;

  st_t st_q[$];
  ln_t ln_q[$];
  logic [7:0] rx_q[$];

  int checks = 0, failures = 0;
  int cyc, cmp_limit, rc;
  bit cmp_on = 0;
  bit busy_m, done_m, aerr_m;
  int addr_m;
  int flag_tx = -1, flag_ack = -1;
  int first_done, first_aerr, first_addr1;
  bit prev_sioc = 1'b1, prev_line = 1'b1, collecting = 1'b0;
  int nbits = 0;
  logic [26:0] sh = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  // ---------------- model ----------------
  task automatic emit(input bit c, input bit o, input bit d, input bit din_v, input bit smp);
    st_t s;
    ln_t l;
    s.busy = busy_m; s.done = done_m; s.aerr = aerr_m; s.din = din_v;
    s.addr = addr_m[7:0];
    l.sioc = c; l.oe = o; l.out = d;
    st_q.push_back(s);
    ln_q.push_back(l);
    if (smp && din_v) aerr_m = 1'b1;
  endtask

  task automatic emit_qtr(input bit c, input bit o, input bit d, input bit din_v, input bit smp_last);
    for (int k = 0; k < QTR; k++) emit(c, o, d, din_v, smp_last && (k == QTR - 1));
  endtask

  task automatic emit_write(input int tx, input logic [15:0] v);
    logic [7:0] by [3];
    bit x, fl;
    by[0] = 8'h42; by[1] = v[15:8]; by[2] = v[7:0];
    emit_qtr(1, 1, 1, 0, 0); emit_qtr(1, 1, 0, 0, 0);
    emit_qtr(1, 1, 0, 0, 0); emit_qtr(0, 1, 0, 0, 0);
    for (int b = 0; b < 3; b++) begin
      for (int i = 7; i >= 0; i--) begin
        x = by[b][i];
        emit_qtr(0, 1, x, 0, 0); emit_qtr(1, 1, x, 0, 0);
        emit_qtr(1, 1, x, 0, 0); emit_qtr(0, 1, x, 0, 0);
      end
      fl = (tx == flag_tx) && (b == flag_ack);
      emit_qtr(0, 0, 1, fl, 0); emit_qtr(1, 0, 1, fl, 0);
      emit_qtr(1, 0, 1, fl, 1); emit_qtr(0, 0, 1, fl, 0);
    end
    emit_qtr(0, 1, 0, 0, 0); emit_qtr(1, 1, 0, 0, 0);
    emit_qtr(1, 1, 1, 0, 0); emit_qtr(1, 1, 1, 0, 0);
    for (int g = 0; g < 4; g++) emit_qtr(1, 0, 1, 0, 0);
  endtask

  task automatic build_model();
    int tx;
    bit fin;
    st_q.delete(); ln_q.delete();
    ln_q.push_back(3'b101);
    busy_m = 1; done_m = 0; aerr_m = 0; tx = 0; fin = 0;
    for (int i = 0; i < 256; i++) begin
      addr_m = i;
      emit(1, 0, 1, 0, 0);
      emit(1, 0, 1, 0, 0);
      if (rom[i] == 16'hFFFF) begin
        fin = 1;
      end else if (rom[i] == 16'hFFF0) begin
        for (int d = 0; d < DLY; d++) emit(1, 0, 1, 0, 0);
      end else begin
        emit_write(tx, rom[i]);
        tx++;
      end
      if (fin || i == 255) begin
        emit(1, 0, 1, 0, 0);
        busy_m = 0; done_m = 1;
        emit(1, 0, 1, 0, 0);
        break;
      end
    end
  endtask

  // ------------- per-cycle step: decode + compare -------------
  task automatic step();
    logic line;
    st_t s;
    ln_t l;
    int f0;
    @(posedge clk);
    #1;
    rc++;
    line = siod_oe ? siod_out : 1'b1;
    if (sioc && prev_sioc && prev_line && !line) begin
      nbits = 0; collecting = 1;
    end else if (collecting && sioc && !prev_sioc) begin
      sh = {sh[25:0], line};
      nbits++;
      if (nbits == 27) begin
        rx_q.push_back(sh[26:19]); rx_q.push_back(sh[17:10]); rx_q.push_back(sh[8:1]);
        collecting = 0;
      end
    end
    prev_sioc = sioc; prev_line = line;
    if (rc >= 0) begin
      if (done && first_done < 0) first_done = rc;
      if (ack_err && first_aerr < 0) first_aerr = rc;
      if (rom_addr == 8'd1 && first_addr1 < 0) first_addr1 = rc;
    end
    if (cmp_on) begin
      s = st_q[cyc]; l = ln_q[cyc];
      f0 = failures;
      chk($sformatf("trace@%0d", cyc),
          32'({sioc, siod_oe, siod_oe & siod_out, busy, done, ack_err, rom_addr}),
          32'({l.sioc, l.oe, l.oe & l.out, s.busy, s.done, s.aerr, s.addr}));
      siod_in = s.din;
      cyc++;
      if (failures != f0 || cyc >= st_q.size() || cyc >= cmp_limit) cmp_on = 0;
    end else begin
      siod_in = 1'b0;
    end
  endtask

  task automatic run(input int limit);
    build_model();
    rx_q.delete();
    first_done = -1; first_aerr = -1; first_addr1 = -1;
    cmp_limit = limit; cyc = 0; cmp_on = 1; rc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic finish_run();
    int budget;
    budget = st_q.size() + 20;
    while (cmp_on && budget > 0) begin
      step();
      budget--;
    end
    repeat (3) step();
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 256; i++) rom[i] = 16'hFFFF;
  endtask

  task automatic chk_rx(input logic [7:0] e0, input logic [7:0] e1, input logic [7:0] e2);
    chk("rx_count", rx_q.size(), 3);
    if (rx_q.size() == 3) begin
      chk("rx_id", 32'(rx_q[0]), 32'(e0));
      chk("rx_reg", 32'(rx_q[1]), 32'(e1));
      chk("rx_val", 32'(rx_q[2]), 32'(e2));
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; siod_in = 1'b0; rc = -1;
    clear_rom();
    repeat (3) step();
    chk("rst_sioc", 32'(sioc), 1);
    chk("rst_siod_out", 32'(siod_out), 1);
    chk("rst_siod_oe", 32'(siod_oe), 0);
    chk("rst_rom_addr", 32'(rom_addr), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_ack_err", 32'(ack_err), 0);
    rst = 1'b0;
    repeat (2) step();

    // single write then terminator
    clear_rom(); rom[0] = 16'h1280;
    run(1 << 30); finish_run();
    chk("t1_done_latency", first_done, 2 + 240 + 3);
    chk("t1_ack_err", 32'(ack_err), 0);
    chk_rx(8'h42, 8'h12, 8'h80);

    // delay marker before a write
    clear_rom(); rom[0] = 16'hFFF0; rom[1] = 16'h1101;
    run(1 << 30); finish_run();
    chk("t2_addr1_cycle", first_addr1, 2 + DLY);
    chk("t2_done", 32'(done), 1);
    chk_rx(8'h42, 8'h11, 8'h01);

    // empty table
    clear_rom();
    run(1 << 30); finish_run();
    chk("t3_done_latency", first_done, 3);
    chk("t3_rx_count", rx_q.size(), 0);

    // NACK in the second ack slot
    clear_rom(); rom[0] = 16'h1280;
    flag_tx = 0; flag_ack = 1;
    run(1 << 30); finish_run();
    flag_tx = -1; flag_ack = -1;
    chk("t4_ack_err_cycle", first_aerr, 2 + 4 * QTR + 17 * 4 * QTR + 3 * QTR);
    chk("t4_ack_err", 32'(ack_err), 1);
    chk("t4_done", 32'(done), 1);
    chk_rx(8'h42, 8'h12, 8'h80);

    // start ignored mid-transfer, then reset mid-BITS, then rerun
    clear_rom(); rom[0] = 16'h1280;
    run(40);
    while (rc < 19) step();
    start = 1'b1; step(); start = 1'b0;
    while (rc < 39) step();
    rst = 1'b1; step();
    chk("t5_rst_sioc", 32'(sioc), 1);
    chk("t5_rst_siod_oe", 32'(siod_oe), 0);
    chk("t5_rst_busy", 32'(busy), 0);
    chk("t5_rst_rom_addr", 32'(rom_addr), 0);
    rst = 1'b0; step();
    run(1 << 30); finish_run();
    chk("t5_rerun_done_latency", first_done, 245);
    chk_rx(8'h42, 8'h12, 8'h80);

    // full table without terminator
    for (int i = 0; i < 256; i++) rom[i] = {8'(i), ~8'(i)};
    run(1 << 30); finish_run();
    chk("t6_tx_count", rx_q.size(), 768);
    chk("t6_rom_addr_end", 32'(rom_addr), 255);
    chk("t6_done", 32'(done), 1);
    if (rx_q.size() == 768) begin
      for (int i = 0; i < 256; i += 51) begin
        chk($sformatf("t6_reg%0d", i), 32'(rx_q[3 * i + 1]), i);
        chk($sformatf("t6_val%0d", i), 32'(rx_q[3 * i + 2]), 255 - i);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
